// File: rtl/mc_pkg.sv
// mc_pkg: state, opcode/funct and control-field encodings shared by the controller and datapath
package mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM    = 4'd3,
    S_WB     = 4'd4,
    S_ERR    = 4'd15
  } state_e;
  typedef enum logic [3:0] {C_BAD, C_ALU, C_LOAD, C_STORE, C_BEQ, C_BGTZ, C_J, C_JAL, C_JR} cls_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] NPC_SEQ  = 3'd0;
  localparam logic [2:0] NPC_BR   = 3'd1;
  localparam logic [2:0] NPC_J    = 3'd2;
  localparam logic [2:0] NPC_JR   = 3'd3;
  localparam logic [2:0] M2R_ALU  = 3'd0;
  localparam logic [2:0] M2R_MEM  = 3'd1;
  localparam logic [2:0] M2R_LUI  = 3'd2;
  localparam logic [2:0] M2R_PC   = 3'd3;
  localparam logic [2:0] M2R_LB   = 3'd4;
  localparam logic [1:0] RD_RT    = 2'd0;
  localparam logic [1:0] RD_RD    = 2'd1;
  localparam logic [1:0] RD_RA    = 2'd2;
  typedef struct packed {
    cls_e       cls;
    logic       alu_src_b;
    logic [1:0] reg_dst;
    logic [2:0] alu_ctrl;
    logic [2:0] mem2reg;
  } ctl_t;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: opcode/funct to instruction class and control fields; lb only with MC_CTRL_LB_EN
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctl_t       ctl
);
  always_comb begin
    ctl = '{cls: C_BAD, alu_src_b: 1'b0, reg_dst: RD_RT, alu_ctrl: ALU_ADD, mem2reg: M2R_ALU};
    case (opcode)
      OP_RTYPE: begin
        ctl.cls = funct == FN_ADDU || funct == FN_SUBU ? C_ALU : funct == FN_JR ? C_JR : C_BAD;
        ctl.reg_dst = RD_RD;
        ctl.alu_ctrl = funct == FN_SUBU ? ALU_SUB : ALU_ADD;
      end
      OP_ORI: begin
        ctl.cls = C_ALU;
        ctl.alu_ctrl = ALU_OR;
        ctl.alu_src_b = 1'b1;
      end
      OP_LUI: begin
        ctl.cls = C_ALU;
        ctl.mem2reg = M2R_LUI;
      end
      OP_LW: begin
        ctl.cls = C_LOAD;
        ctl.alu_src_b = 1'b1;
        ctl.mem2reg = M2R_MEM;
      end
`ifdef MC_CTRL_LB_EN
      OP_LB: begin
        ctl.cls = C_LOAD;
        ctl.alu_src_b = 1'b1;
        ctl.mem2reg = M2R_LB;
      end
`endif
      OP_SW: begin
        ctl.cls = C_STORE;
        ctl.alu_src_b = 1'b1;
      end
      OP_BEQ:  ctl.cls = C_BEQ;
      OP_BGTZ: ctl.cls = C_BGTZ;
      OP_J:    ctl.cls = C_J;
      OP_JAL: begin
        ctl.cls = C_JAL;
        ctl.reg_dst = RD_RA;
        ctl.mem2reg = M2R_PC;
      end
      default: ctl.cls = C_BAD;
    endcase
  end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle FSM and memory wait/timeout counter; MC_CTRL_LB_EN enables lb decode
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       greater_zero,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       err,
  output logic       alu_src_b,
  output logic [1:0] reg_dst,
  output logic [2:0] alu_ctrl,
  output logic [2:0] mem2reg,
  output logic [2:0] npc_sel,
  output logic [3:0] state
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  state_e st, st_n;
  ctl_t ctl;
  logic [CW-1:0] cnt;
  logic wt, tmo, hold;
  mc_decode u_dec (.opcode(opcode), .funct(funct), .ctl(ctl));
  // FETCH and MEM always have an access in flight, so waiting is state-based
  assign wt = !reset && !mem_ready && (st == S_FETCH || st == S_MEM);
  assign tmo = wt && cnt == CW'(MEM_TIMEOUT - 1);
  always_ff @(posedge clk) begin
    st <= reset ? S_FETCH : st_n;
    cnt <= (reset || !wt || st_n != st) ? '0 : cnt + CW'(1);
  end
  always_comb begin
    st_n = st;
    ir_write = 1'b0;
    pc_write = 1'b0;
    reg_write = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    err = 1'b0;
    npc_sel = NPC_SEQ;
    hold = 1'b0;
    if (!reset)
      case (st)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          st_n = tmo ? S_ERR : mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: st_n = ctl.cls == C_BAD ? S_ERR : S_EXEC;
        S_EXEC: begin
          hold = 1'b1;
          st_n = ctl.cls == C_ALU ? S_WB :
                 ctl.cls == C_LOAD || ctl.cls == C_STORE ? S_MEM :
                 ctl.cls == C_BAD ? S_ERR : S_FETCH;
          pc_write = st_n == S_FETCH;
          reg_write = ctl.cls == C_JAL;
          npc_sel = ctl.cls == C_BEQ ? (zero ? NPC_BR : NPC_SEQ) :
                    ctl.cls == C_BGTZ ? (greater_zero ? NPC_BR : NPC_SEQ) :
                    ctl.cls == C_J || ctl.cls == C_JAL ? NPC_J :
                    ctl.cls == C_JR ? NPC_JR : NPC_SEQ;
        end
        S_MEM: begin
          hold = 1'b1;
          mem_read = ctl.cls == C_LOAD;
          mem_write = ctl.cls == C_STORE;
          pc_write = mem_ready && ctl.cls == C_STORE;
          st_n = tmo ? S_ERR : !mem_ready ? S_MEM : ctl.cls == C_LOAD ? S_WB : S_FETCH;
        end
        S_WB: begin
          hold = 1'b1;
          reg_write = 1'b1;
          pc_write = 1'b1;
          st_n = S_FETCH;
        end
        S_ERR: err = 1'b1;
        default: st_n = S_ERR;
      endcase
  end
  assign state = st;
  assign alu_src_b = hold & ctl.alu_src_b;
  assign reg_dst = hold ? ctl.reg_dst : RD_RT;
  assign alu_ctrl = hold ? ctl.alu_ctrl : ALU_ADD;
  assign mem2reg = hold ? ctl.mem2reg : M2R_ALU;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed instruction sequences with hand-computed cycle-by-cycle expectations
module tb_mc_ctrl;
  logic clk = 1'b0;
  logic reset, zero, greater_zero, mem_ready;
  logic [5:0] opcode, funct;
  logic ir_write, pc_write, reg_write, mem_read, mem_write, err, alu_src_b;
  logic [1:0] reg_dst;
  logic [2:0] alu_ctrl, mem2reg, npc_sel;
  logic [3:0] state;
  int checks = 0;
  int errors = 0;
  int pcw = 0;
  always #5 clk = ~clk;
  mc_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .greater_zero(greater_zero), .mem_ready(mem_ready), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .err(err), .alu_src_b(alu_src_b), .reg_dst(reg_dst),
    .alu_ctrl(alu_ctrl), .mem2reg(mem2reg), .npc_sel(npc_sel), .state(state)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic rdy);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    #1;
    pcw += int'(pc_write);
  endtask
  initial begin
    reset = 1'b1; zero = 1'b0; greater_zero = 1'b0; mem_ready = 1'b1;
    opcode = 6'b000000; funct = 6'b000000;
    cyc(1); cyc(1);
    chk("rst_state", state, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_err", err, 0);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_npc_sel", npc_sel, 0);
    // addu
    funct = 6'b100001; reset = 1'b0; pcw = 0; #1;
    chk("addu_fetch_state", state, 0);
    chk("addu_fetch_rd", mem_read, 1);
    chk("addu_ir_write", ir_write, 1);
    cyc(1); chk("addu_decode", state, 1);
    cyc(1); chk("addu_exec", state, 2);
    chk("addu_exec_regdst", reg_dst, 1);
    chk("addu_exec_nowr", reg_write, 0);
    cyc(1); chk("addu_wb", state, 4);
    chk("addu_wb_reg_write", reg_write, 1);
    chk("addu_wb_regdst", reg_dst, 1);
    chk("addu_wb_pc_write", pc_write, 1);
    cyc(1); chk("addu_done", state, 0);
    chk("addu_pc_pulses", pcw, 1);
    // lw with three ready-low cycles in MEM
    opcode = 6'b100011; pcw = 0;
    cyc(1); chk("lw_decode", state, 1);
    cyc(1); chk("lw_exec", state, 2);
    chk("lw_alu_src_b", alu_src_b, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(i == 3);
      chk("lw_mem_state", state, 3);
      chk("lw_mem_read", mem_read, 1);
      chk("lw_mem_nowrite", mem_write, 0);
    end
    cyc(1); chk("lw_wb", state, 4);
    chk("lw_mem2reg", mem2reg, 1);
    chk("lw_reg_write", reg_write, 1);
    cyc(1); chk("lw_done", state, 0);
    chk("lw_pc_pulses", pcw, 1);
    // beq taken then not taken
    opcode = 6'b000100; zero = 1'b1; pcw = 0;
    cyc(1); cyc(1);
    chk("beq1_exec", state, 2);
    chk("beq1_npc", npc_sel, 1);
    chk("beq1_pcw", pc_write, 1);
    chk("beq1_noreg", reg_write, 0);
    cyc(1); chk("beq1_done", state, 0);
    zero = 1'b0;
    cyc(1); cyc(1);
    chk("beq0_npc", npc_sel, 0);
    chk("beq0_pcw", pc_write, 1);
    chk("beq0_noreg", reg_write, 0);
    cyc(1); chk("beq0_done", state, 0);
    chk("beq_pc_pulses", pcw, 2);
    // jal
    opcode = 6'b000011;
    cyc(1); cyc(1);
    chk("jal_npc", npc_sel, 2);
    chk("jal_reg_write", reg_write, 1);
    chk("jal_regdst", reg_dst, 2);
    chk("jal_mem2reg", mem2reg, 3);
    cyc(1); chk("jal_done", state, 0);
    // sw, reset during MEM wait
    opcode = 6'b101011;
    cyc(1); cyc(1); chk("sw_exec", state, 2);
    cyc(0); chk("sw_mem", state, 3);
    chk("sw_mem_write", mem_write, 1);
    chk("sw_no_read", mem_read, 0);
    cyc(0); chk("sw_mem_wait", mem_write, 1);
    reset = 1'b1;
    cyc(0);
    chk("sw_rst_write", mem_write, 0);
    chk("sw_rst_state", state, 0);
    // fetch timeout
    reset = 1'b0; #1;
    chk("to_first_wait", mem_read, 1);
    repeat (14) cyc(0);
    chk("to_wait15_state", state, 0);
    chk("to_wait15_err", err, 0);
    cyc(0);
    chk("to_state", state, 15);
    chk("to_err", err, 1);
    chk("to_no_read", mem_read, 0);
    cyc(1); chk("to_sticky", err, 1);
    reset = 1'b1;
    cyc(1);
    chk("to_rst_state", state, 0);
    chk("to_rst_err", err, 0);
    // unsupported opcode
    reset = 1'b0; opcode = 6'b111111; #1;
    cyc(1); chk("bad_decode", state, 1);
    cyc(1); chk("bad_state", state, 15);
    chk("bad_err", err, 1);
    chk("bad_pcw", pc_write, 0);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0; opcode = 6'b100000; pcw = 0; #1;
    cyc(1); cyc(1);
`ifdef MC_CTRL_LB_EN
    chk("lb_exec", state, 2);
    cyc(1); chk("lb_mem", state, 3);
    chk("lb_mem_read", mem_read, 1);
    cyc(1); chk("lb_wb", state, 4);
    chk("lb_mem2reg", mem2reg, 4);
    chk("lb_reg_write", reg_write, 1);
    cyc(1); chk("lb_done", state, 0);
    chk("lb_pc_pulses", pcw, 1);
`else
    chk("lb_err_state", state, 15);
    chk("lb_err", err, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of wait cycles on mem_ready before an error is raised.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  instruction bits [31:26], taken from the instruction register.
REQ-005 funct  input  6  instruction bits [5:0].
REQ-006 zero  input  1  ALU result equals 0.
REQ-007 greater_zero  input  1  ALU signed source A is greater than 0.
REQ-008 mem_ready  input  1  the memory has completed the current access this cycle.
REQ-009 Strobe outputs, each output 1 bit: ir_write, pc_write, reg_write, mem_read, mem_write, err.
REQ-010 Encoded outputs: alu_src_b (1 bit), reg_dst (2 bits), alu_ctrl (3 bits), mem2reg (3 bits), npc_sel (3 bits), state (4 bits).

Function
REQ-011 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and ERR.
REQ-012 In FETCH, the block SHALL assert mem_read and hold it until mem_ready is seen.
  - On the mem_ready cycle it SHALL pulse ir_write for 1 cycle and go to DECODE.
REQ-013 DECODE SHALL always go to EXEC, except for an unsupported opcode/funct, which SHALL go to ERR.
REQ-014 EXEC behaviour by instruction class:
  - addu/subu/ori/lui: go to WB.
  - lw/sw: go to MEM.
  - beq, bgtz, j, jal, jr: finish in EXEC (pc_write pulse, return to FETCH).
REQ-015 For beq, npc_sel SHALL be 1 when zero=1, otherwise 0.
  - For bgtz, npc_sel SHALL be 1 when greater_zero=1, otherwise 0.
  - For j and jal, npc_sel SHALL be 2; for jr, 3.
  - jal SHALL also assert reg_write with reg_dst=2 and mem2reg=3 in the same cycle.
REQ-016 In MEM, the block SHALL hold mem_read (lw) or mem_write (sw) until mem_ready.
  - lw then goes to WB.
  - sw pulses pc_write with npc_sel=0 and goes to FETCH.
REQ-017 WB SHALL pulse reg_write and pc_write (npc_sel=0) for exactly 1 cycle, then go to FETCH.
REQ-018 Per-instruction control values:
  - addu: alu_ctrl=0, reg_dst=1.
  - subu: alu_ctrl=1, reg_dst=1.
  - ori: alu_ctrl=2, alu_src_b=1.
  - lui: mem2reg=2.
  - lw/sw: alu_ctrl=0, alu_src_b=1.
  - lw: mem2reg=1.
  - These values SHALL be held stable from EXEC until the instruction finishes.
REQ-019 A wait counter SHALL count cycles in which mem_read or mem_write is high and mem_ready is low.
  - It SHALL clear on mem_ready and on every state change.
  - When it reaches MEM_TIMEOUT, the FSM SHALL go to ERR.
REQ-020 ERR SHALL hold err=1 with every strobe at 0 until reset; it is a sticky state.
REQ-021 mem_read and mem_write SHALL never be high in the same cycle.
  - reg_write and mem_write SHALL never be high in the same cycle.
REQ-022 Each instruction SHALL produce exactly one pc_write pulse.
  - Latency with mem_ready already high: ALU 4 cycles, lw 5, sw 4, branch/jump 3.
REQ-023 state SHALL output the current state encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=15.

Reset
REQ-024 On reset, the block SHALL enter FETCH, clear the wait counter and drive all strobes and err to 0.
  - All encoded outputs SHALL be driven to 0.
REQ-025 A reset asserted mid-access SHALL drop mem_read/mem_write on the next cycle; reset SHALL take priority over mem_ready.

Configuration
REQ-026 With MC_CTRL_LB_EN defined, opcode 100000 (lb) SHALL be supported.
  - It is sequenced like lw, with mem2reg=4 in WB.
REQ-027 Without MC_CTRL_LB_EN, opcode 100000 SHALL be treated as unsupported and go to ERR.

Structure
REQ-028 Package mc_pkg SHALL hold the following constants, shared with the datapath:
  - state encodings;
  - opcode/funct constants;
  - alu_ctrl, npc_sel, mem2reg and reg_dst encodings.
REQ-029 One combinational sub-module, mc_decode, SHALL map opcode/funct to instruction class and control values.
  - mc_ctrl SHALL hold the FSM and the wait counter.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
  - addu (op 0, funct 100001), mem_ready tied 1: states 0,1,2,4,0; reg_write at cycle 4 with reg_dst=1; one pc_write.
  - lw with mem_ready delayed 3 cycles in MEM: mem_read held 4 cycles, then WB with mem2reg=1; 8 cycles total.
  - beq with zero=1, then zero=0: npc_sel=1, then 0, in EXEC; no reg_write.
  - mem_ready held 0 in FETCH with MEM_TIMEOUT=15: err=1 after 15 wait cycles; reset returns to FETCH with err=0.
  - Opcode 100000: lb completes with mem2reg=4 when MC_CTRL_LB_EN is defined; ERR when it is not.
  - Reset asserted during sw MEM wait: mem_write=0 next cycle; state=0.
